// File: rtl/squash_pkg.sv
// Shared effect ids, FSM state codes and per-effect lookups for the squash sound scheduler.
// Effect ids double as priority rank: a larger id always wins.
package squash_pkg;

  typedef enum logic [1:0] {
    ID_NONE   = 2'd0,
    ID_WALL   = 2'd1,
    ID_PADDLE = 2'd2,
    ID_MISS   = 2'd3
  } effect_id_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  function automatic int unsigned half_for(input logic [1:0] id, input int unsigned wall_h,
                                           input int unsigned paddle_h, input int unsigned miss_h);
    case (id)
      ID_WALL:   return wall_h;
      ID_PADDLE: return paddle_h;
      ID_MISS:   return miss_h;
      default:   return 1;
    endcase
  endfunction

  function automatic int unsigned frames_for(input logic [1:0] id, input int unsigned wall_f,
                                             input int unsigned paddle_f, input int unsigned miss_f);
    case (id)
      ID_WALL:   return wall_f;
      ID_PADDLE: return paddle_f;
      ID_MISS:   return miss_f;
      default:   return 1;
    endcase
  endfunction

  // mask is one-hot per effect: {miss, paddle, wall}
  function automatic logic [2:0] id_bit(input logic [1:0] id);
    case (id)
      ID_WALL:   return 3'b001;
      ID_PADDLE: return 3'b010;
      ID_MISS:   return 3'b100;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] top_id(input logic [2:0] mask);
    if (mask[2]) return ID_MISS;
    if (mask[1]) return ID_PADDLE;
    if (mask[0]) return ID_WALL;
    return ID_NONE;
  endfunction

  function automatic logic [1:0] max_id(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/squash_tone_gen.sv
// Square-wave generator: divider counts 0..half-1 and toggles phase on each wrap.
// clear has priority over run so a new effect always starts from phase 0.
module squash_tone_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             run,
  input  logic [DIV_W-1:0] half,
  output logic             phase
);

  logic [DIV_W-1:0] div_q, div_d;
  logic             phase_q, phase_d;

  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    if (clear) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else if (run) begin
      if (div_q == half - DIV_W'(1)) begin
        div_d   = '0;
        phase_d = ~phase_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/squash_sound_seq.sv
// Sound-effect scheduler: arbitrates wall/paddle/miss requests onto one speaker pin
// with priority preemption, a single pending slot, pause (HOLD) and mute.
module squash_sound_seq
  import squash_pkg::*;
#(
  parameter int          DIV_W         = 16,
  parameter int unsigned WALL_HALF     = 28409,
  parameter int unsigned PADDLE_HALF   = 14205,
  parameter int unsigned MISS_HALF     = 56818,
  parameter int          DUR_W         = 6,
  parameter int unsigned WALL_FRAMES   = 4,
  parameter int unsigned PADDLE_FRAMES = 6,
  parameter int unsigned MISS_FRAMES   = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       pause,
  input  logic       mute,
  input  logic       req_wall,
  input  logic       req_paddle,
  input  logic       req_miss,
  output logic       speaker,
  output logic       busy,
  output logic [1:0] active_id,
  output logic [2:0] grant
);

  logic [1:0]       state_q, state_d;
  logic [1:0]       active_q, active_d;
  logic [1:0]       pend_q, pend_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [2:0]       grant_q, grant_d;
  logic             mute_q;

  logic [2:0]       req_mask, idle_mask;
  logic [1:0]       req_hi, req_sec, idle_top, start_id;
  logic             tone_clear, tone_run, tone_phase;
  logic [DIV_W-1:0] tone_half;

  always_comb begin
    req_mask  = {req_miss, req_paddle, req_wall};
    req_hi    = top_id(req_mask);
    req_sec   = top_id(req_mask & ~id_bit(req_hi));
    // From IDLE the pending entry competes with fresh requests on equal terms.
    idle_mask = req_mask | id_bit(pend_q);
    idle_top  = top_id(idle_mask);

    state_d    = state_q;
    active_d   = active_q;
    pend_d     = pend_q;
    dur_d      = dur_q;
    grant_d    = 3'b000;
    start_id   = ID_NONE;
    tone_clear = 1'b0;
    tone_run   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pause) begin
          pend_d = max_id(pend_q, req_hi);
        end else begin
          start_id = idle_top;
          pend_d   = top_id(idle_mask & ~id_bit(idle_top));
        end
      end
      ST_PLAY: begin
        if (pause) begin
          state_d = ST_HOLD;
          pend_d  = max_id(pend_q, req_hi);
        end else begin
          tone_run = 1'b1;
          if (frame_tick && dur_q == DUR_W'(1)) begin
            // End tick: a coinciding request only goes through the pending slot.
            start_id = max_id(pend_q, req_hi);
            pend_d   = ID_NONE;
            if (start_id == ID_NONE) begin
              state_d  = ST_IDLE;
              active_d = ID_NONE;
            end
          end else if (req_hi > active_q) begin
            start_id = req_hi;
            pend_d   = max_id(pend_q, req_sec);
          end else begin
            pend_d = max_id(pend_q, req_hi);
            if (frame_tick) dur_d = dur_q - DUR_W'(1);
          end
        end
      end
      ST_HOLD: begin
        pend_d = max_id(pend_q, req_hi);
        if (!pause) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase

    if (start_id != ID_NONE) begin
      state_d    = ST_PLAY;
      active_d   = start_id;
      dur_d      = DUR_W'(frames_for(start_id, WALL_FRAMES, PADDLE_FRAMES, MISS_FRAMES));
      grant_d    = id_bit(start_id);
      tone_clear = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      active_q <= ID_NONE;
      pend_q   <= ID_NONE;
      dur_q    <= '0;
      grant_q  <= 3'b000;
      mute_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      dur_q    <= dur_d;
      grant_q  <= grant_d;
      mute_q   <= mute;
    end
  end

  assign tone_half = DIV_W'(half_for(active_q, WALL_HALF, PADDLE_HALF, MISS_HALF));

  squash_tone_gen #(.DIV_W(DIV_W)) u_tone (
    .clk   (clk),
    .reset (reset),
    .clear (tone_clear),
    .run   (tone_run),
    .half  (tone_half),
    .phase (tone_phase)
  );

  assign speaker   = tone_phase & (state_q == ST_PLAY) & ~mute_q;
  assign busy      = (state_q != ST_IDLE);
  assign active_id = active_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_squash_sound_seq.sv
// Bench for squash_sound_seq: directed scenarios with literal expectations, then random
// traffic checked every cycle against an effect-level model of the scheduler.
module tb_squash_sound_seq;

  localparam int WH = 4, PH = 2, MH = 8;
  localparam int WF = 2, PF = 3, MF = 4;

  logic       clk = 1'b0;
  logic       reset, frame_tick, pause, mute, req_wall, req_paddle, req_miss;
  logic       speaker, busy;
  logic [1:0] active_id;
  logic [2:0] grant;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [2:0] exp_q[$];

  // model: current effect, paused flag, frames left, pending effect, running clocks since start
  int         m_act, m_hold, m_left, m_pend, m_run, m_mute;
  logic [2:0] m_grant;

  always #5 clk = ~clk;

  squash_sound_seq #(
    .DIV_W(16), .WALL_HALF(WH), .PADDLE_HALF(PH), .MISS_HALF(MH),
    .DUR_W(6), .WALL_FRAMES(WF), .PADDLE_FRAMES(PF), .MISS_FRAMES(MF)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .pause(pause), .mute(mute),
    .req_wall(req_wall), .req_paddle(req_paddle), .req_miss(req_miss),
    .speaker(speaker), .busy(busy), .active_id(active_id), .grant(grant)
  );

  function automatic int half_of(input int id);
    return (id == 1) ? WH : (id == 2) ? PH : MH;
  endfunction

  function automatic int frames_of(input int id);
    return (id == 1) ? WF : (id == 2) ? PF : MF;
  endfunction

  function automatic int top_of(input int mask);
    for (int i = 3; i >= 1; i--) if (((mask >> i) & 1) == 1) return i;
    return 0;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_start(input int t);
    m_act   = t;
    m_left  = frames_of(t);
    m_run   = 0;
    m_hold  = 0;
    m_grant = 3'(1 << (t - 1));
  endtask

  always @(posedge clk) begin
    int reqs, best, second, mask, t, p;
    reqs   = (req_wall ? 2 : 0) | (req_paddle ? 4 : 0) | (req_miss ? 8 : 0);
    best   = top_of(reqs);
    second = top_of(reqs & ~(1 << best));
    m_grant = 3'b000;
    if (reset) begin
      m_act = 0; m_hold = 0; m_left = 0; m_pend = 0; m_run = 0; m_mute = 0;
    end else begin
      m_mute = mute ? 1 : 0;
      if (m_act == 0) begin
        if (pause) m_pend = imax(m_pend, best);
        else begin
          mask = reqs | ((m_pend != 0) ? (1 << m_pend) : 0);
          t = top_of(mask);
          if (t != 0) begin
            p = top_of(mask & ~(1 << t));
            model_start(t);
            m_pend = p;
          end
        end
      end else if (m_hold != 0) begin
        m_pend = imax(m_pend, best);
        if (!pause) m_hold = 0;
      end else if (pause) begin
        m_hold = 1;
        m_pend = imax(m_pend, best);
      end else begin
        m_run++;
        if (frame_tick && m_left == 1) begin
          p = imax(m_pend, best);
          m_pend = 0;
          if (p != 0) model_start(p);
          else m_act = 0;
        end else if (best > m_act) begin
          model_start(best);
          m_pend = imax(m_pend, second);
        end else begin
          m_pend = imax(m_pend, best);
          if (frame_tick) m_left--;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic exp_spk;
    logic [2:0] g;
    if (chk_en) begin
      exp_spk = (m_act != 0) && (m_hold == 0) && (m_mute == 0) &&
                (((m_run / half_of(m_act)) % 2) == 1);
      chk("speaker", 8'(speaker), 8'(exp_spk));
      chk("busy", 8'(busy), 8'(m_act != 0));
      chk("active_id", 8'(active_id), 8'(m_act));
      chk("grant", 8'(grant), 8'(m_grant));
      if (m_grant != 3'b000) exp_q.push_back(m_grant);
      if (grant != 3'b000) begin
        if (exp_q.size() == 0) chk("grant_order_empty", 8'(grant), 8'd0);
        else begin
          g = exp_q.pop_front();
          chk("grant_order", 8'(grant), 8'(g));
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] r);
    {req_miss, req_paddle, req_wall} = r;
    cyc();
    {req_miss, req_paddle, req_wall} = 3'b000;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic tick_gap(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (i != 0) repeat (gap) cyc();
      tick();
    end
  endtask

  task automatic wait_level(input logic lvl, output int n);
    n = 0;
    while (speaker !== lvl && n < 64) begin
      cyc();
      n++;
    end
  endtask

  initial begin
    int n, highs;
    reset = 1'b1; frame_tick = 1'b0; pause = 1'b0; mute = 1'b0;
    req_wall = 1'b0; req_paddle = 1'b0; req_miss = 1'b0;
    repeat (3) cyc();
    chk_en = 1'b1;
    reset = 1'b0;
    chk("reset_speaker", 8'(speaker), 8'd0);
    chk("reset_busy", 8'(busy), 8'd0);
    chk("reset_active", 8'(active_id), 8'd0);
    chk("reset_grant", 8'(grant), 8'd0);
    repeat (2) cyc();

    // single wall effect
    req(3'b001);
    chk("wall_grant", 8'(grant), 8'b001);
    chk("wall_active", 8'(active_id), 8'd1);
    wait_level(1'b1, n);
    chk("wall_first_rise", 8'(n), 8'd4);
    wait_level(1'b0, n);
    chk("wall_half_period", 8'(n), 8'd4);
    tick();
    chk("wall_busy_mid", 8'(busy), 8'd1);
    repeat (3) cyc();
    tick();
    chk("wall_end_busy", 8'(busy), 8'd0);
    chk("wall_end_active", 8'(active_id), 8'd0);
    repeat (2) cyc();

    // paddle and wall together: paddle first, wall from pending
    req(3'b011);
    chk("pw_grant", 8'(grant), 8'b010);
    chk("pw_active", 8'(active_id), 8'd2);
    cyc();
    chk("pw_grant_pulse", 8'(grant), 8'd0);
    wait_level(1'b1, n);
    chk("paddle_rise", 8'(n), 8'd1);
    wait_level(1'b0, n);
    chk("paddle_half_period", 8'(n), 8'd2);
    tick_gap(3, 2);
    chk("pw_next_grant", 8'(grant), 8'b001);
    chk("pw_next_active", 8'(active_id), 8'd1);
    chk("pw_next_busy", 8'(busy), 8'd1);
    tick_gap(2, 2);
    chk("pw_done", 8'(busy), 8'd0);
    repeat (2) cyc();

    // miss preempts wall; wall is discarded
    req(3'b001);
    repeat (3) cyc();
    req(3'b100);
    chk("pre_grant", 8'(grant), 8'b100);
    chk("pre_active", 8'(active_id), 8'd3);
    wait_level(1'b1, n);
    chk("pre_miss_rise", 8'(n), 8'd8);
    tick_gap(4, 2);
    chk("pre_end_active", 8'(active_id), 8'd0);
    repeat (3) cyc();
    chk("pre_no_resume", 8'(busy), 8'd0);

    // pending keeps the higher of two lower requests
    req(3'b100);
    cyc();
    req(3'b001);
    cyc();
    req(3'b010);
    tick_gap(4, 2);
    chk("pend_grant", 8'(grant), 8'b010);
    chk("pend_active", 8'(active_id), 8'd2);
    tick_gap(3, 2);
    repeat (3) cyc();
    chk("pend_wall_dropped", 8'(busy), 8'd0);

    // pause mid-paddle
    req(3'b010);
    cyc();
    tick();
    cyc();
    pause = 1'b1;
    cyc();
    chk("pause_busy", 8'(busy), 8'd1);
    chk("pause_speaker", 8'(speaker), 8'd0);
    tick_gap(10, 2);
    chk("pause_still_busy", 8'(busy), 8'd1);
    chk("pause_still_active", 8'(active_id), 8'd2);
    pause = 1'b0;
    cyc();
    tick();
    chk("resume_busy", 8'(busy), 8'd1);
    cyc();
    tick();
    chk("resume_done", 8'(busy), 8'd0);
    repeat (2) cyc();

    // mute during wall: silent, same end timing
    mute = 1'b1;
    req(3'b001);
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      if (speaker === 1'b1) highs++;
      cyc();
    end
    tick();
    chk("mute_busy_mid", 8'(busy), 8'd1);
    repeat (3) cyc();
    tick();
    chk("mute_end_busy", 8'(busy), 8'd0);
    chk("mute_silent", 8'(highs), 8'd0);
    mute = 1'b0;
    repeat (2) cyc();

    // reset mid-miss with wall pending
    req(3'b100);
    cyc();
    req(3'b001);
    repeat (9) cyc();
    reset = 1'b1;
    cyc();
    chk("rst_speaker", 8'(speaker), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_active", 8'(active_id), 8'd0);
    chk("rst_grant", 8'(grant), 8'd0);
    reset = 1'b0;
    repeat (3) cyc();
    chk("rst_pend_empty", 8'(busy), 8'd0);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      req_wall   = ($urandom_range(0, 15) == 0);
      req_paddle = ($urandom_range(0, 15) == 0);
      req_miss   = ($urandom_range(0, 19) == 0);
      frame_tick = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) == 0) pause = ~pause;
      if ($urandom_range(0, 199) == 0) mute = ~mute;
      reset = ($urandom_range(0, 799) == 0);
      cyc();
    end
    {req_miss, req_paddle, req_wall} = 3'b000;
    reset = 1'b0; pause = 1'b0; mute = 1'b0;
    for (int i = 0; i < 300; i++) begin
      frame_tick = ($urandom_range(0, 3) == 0);
      cyc();
    end
    frame_tick = 1'b0;
    cyc();
    chk("drain_idle", 8'(busy), 8'd0);
    chk("grant_queue_empty", 8'(exp_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/squash_sound_seq.md
# squash_sound_seq

Sound-effect scheduler for the solo squash game: arbitrates one-cycle event requests (wall bounce, paddle hit, ball miss) for the single `speaker` output, plays each as a square-wave tone of fixed pitch and frame-counted duration, and handles priority, preemption, one pending slot, pause and mute. It sits between the game's collision logic and the top-level `speaker` pin, replacing the direct tone drive.

## Interface
- `DIV_W`, 16: tone divider width.
- `WALL_HALF`, 28409: half-period in clocks for wall tone (440 Hz at 25 MHz).
- `PADDLE_HALF`, 14205: half-period for paddle tone (880 Hz).
- `MISS_HALF`, 56818: half-period for miss tone (220 Hz).
- `DUR_W`, 6: duration counter width.
- `WALL_FRAMES`, 4 / `PADDLE_FRAMES`, 6 / `MISS_FRAMES`, 30: effect lengths in frames (each ≥1).

- `clk` in 1: the single clock, 25.175 MHz nominal.
- `reset` in 1: synchronous, active-high.
- `frame_tick` in 1: one-cycle pulse per frame (vsync start).
- `pause` in 1: level; freezes playback.
- `mute` in 1: level; silences output only.
- `req_wall`, `req_paddle`, `req_miss` in 1 each: one-cycle event pulses.
- `speaker` out 1: tone output.
- `busy` out 1: an effect is active (playing or paused).
- `active_id` out 2: 0 none, 1 wall, 2 paddle, 3 miss.
- `grant` out 3: one-hot one-cycle pulse {miss,paddle,wall} when an effect starts.

## Operation
- Priority miss > paddle > wall. Priority rank equals id value.
- States: IDLE, PLAY, HOLD.
- IDLE: any request → PLAY with the highest requested id; the highest remaining same-cycle request (if any) goes to pending.
- PLAY: request with id > active_id preempts: restart as that effect; preempted effect discarded (not pended). Request with id ≤ active_id: offered to pending.
- Pending slot (one entry): loaded if empty, or replaced only by strictly higher id. Cleared when it starts.
- Duration: counter loaded with `*_FRAMES` at start; decremented on each `frame_tick` in PLAY, excluding a tick in the start cycle. Effect ends on the tick that takes it to 0.
- End: if pending valid → start pending next cycle (grant pulse), else IDLE.
- `pause` high in PLAY → HOLD: divider, phase, duration frozen; `speaker`=0; `busy`=1; requests still feed the pending slot only (no preemption). `pause` low → PLAY, resumes from frozen values.
- `pause` in IDLE: requests only fill pending; nothing starts until `pause` drops.
- `mute`: forces `speaker`=0; all sequencing unchanged.
- Tone: divider counts 0..HALF-1; at HALF-1 wraps to 0 and toggles phase. Divider and phase cleared on every start. `speaker` = phase & PLAY & ~mute.

## Timing
- Reset: state IDLE, `speaker`=0, `busy`=0, `active_id`=0, `grant`=0, pending empty, counters 0. Reset mid-effect takes effect on the next edge; no residual tone.
- Request at edge N → `grant`, `active_id`, `busy` valid after edge N+1 (registered, 1-cycle latency).
- First `speaker` rise HALF clocks after the start edge; period 2·HALF clocks.
- End tick at edge M → `active_id`=0/`busy`=0 after M+1; if pending is valid, next `grant` after M+1 and `busy` stays high.
- Request coinciding with end tick: treated as arriving during PLAY (pending rules), then pending starts.
- All outputs registered; no combinational input→output paths.

## Structure
- `squash_pkg`: effect id enum (NONE/WALL/PADDLE/MISS), state enum, function mapping id→half-period and id→frames.
- Sub-module `squash_tone_gen`: divider + phase with `clear`, `run`, `half` inputs and a `phase` output.
- Top-level integration: `frame_tick` from the vsync edge, requests from the collision logic.

## Test plan
Bench params: WALL_HALF=4, PADDLE_HALF=2, MISS_HALF=8, frames 2/3/4.
- Reset then `req_wall` → `grant`=001 one cycle later, `speaker` toggles every 4 clocks, ends after 2 `frame_tick`s, `busy`=0.
- `req_wall` and `req_paddle` in the same cycle → paddle plays 3 frames with period 4 clocks, then wall granted immediately after, 2 frames.
- Wall playing, `req_miss` → miss preempts next cycle, divider restarted, wall never resumes after miss ends.
- Miss playing, `req_wall` then `req_paddle` → pending holds paddle; after miss, paddle plays, wall dropped.
- `pause` mid-paddle for 10 frame ticks → `speaker`=0, `busy`=1, duration frozen; after release, remaining frames complete and phase continues from the frozen value.
- `mute` during wall → `speaker`=0, end timing identical to the unmuted run; `reset` mid-miss → all outputs 0 next cycle, pending empty.
